// File: rtl/ahb_master_req_ctrl_pkg.sv
// rtl/ahb_master_req_ctrl_pkg.sv - AHB burst/transfer types and beat-limit helper
// Shared by the master request controller and the slave arbiter burst monitor.
package ahb_master_req_ctrl_pkg;

   typedef enum logic [2:0] {
      SINGLE = 3'b000,
      INCR   = 3'b001,
      WRAP4  = 3'b010,
      INCR4  = 3'b011,
      WRAP8  = 3'b100,
      INCR8  = 3'b101,
      WRAP16 = 3'b110,
      INCR16 = 3'b111
   } hburst_type;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_type;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_XFER = 2'b10
   } state_type;

   // Beats-1 for a burst; the arbiter's count_limit uses the same encoding.
   function automatic logic [3:0] beat_limit(input hburst_type burst, input logic [3:0] len);
      case (burst)
         SINGLE:         beat_limit = 4'd0;
         INCR:           beat_limit = len;
         WRAP4, INCR4:   beat_limit = 4'd3;
         WRAP8, INCR8:   beat_limit = 4'd7;
         WRAP16, INCR16: beat_limit = 4'd15;
         default:        beat_limit = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_addr_next.sv
// rtl/ahb_master_req_ctrl_addr_next.sv - next beat address for incrementing and wrapping bursts
// Non-wrapping bursts use an all-ones mask, which reduces the wrap formula to a plain increment.
module ahb_addr_next
   import ahb_master_req_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int BYTES_PER_BEAT = 4
) (
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  hburst_type            hburst,
   output logic [ADDR_WIDTH-1:0] next_addr
);

   logic [ADDR_WIDTH-1:0] incr_addr;
   logic [ADDR_WIDTH-1:0] wrap_mask;

   assign incr_addr = haddr + ADDR_WIDTH'(BYTES_PER_BEAT);

   always_comb begin
      wrap_mask = '1;
      case (hburst)
         WRAP4:   wrap_mask = ADDR_WIDTH'(4 * BYTES_PER_BEAT - 1);
         WRAP8:   wrap_mask = ADDR_WIDTH'(8 * BYTES_PER_BEAT - 1);
         WRAP16:  wrap_mask = ADDR_WIDTH'(16 * BYTES_PER_BEAT - 1);
         default: wrap_mask = '1;
      endcase
   end

   assign next_addr = (haddr & ~wrap_mask) | (incr_addr & wrap_mask);

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// rtl/ahb_master_req_ctrl.sv - master-side AHB burst request and address-phase sequencer
// One burst command in, hreq held until the last beat is granted.
module ahb_master_req_ctrl
   import ahb_master_req_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int BYTES_PER_BEAT = 4
) (
   input  logic                  hclk,
   input  logic                  hreset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_write,
   input  hburst_type            cmd_burst,
   input  logic [3:0]            cmd_len,
   output logic                  hreq,
   input  logic                  hgrant,
   input  logic                  hwait,
   output logic [ADDR_WIDTH-1:0] haddr,
   output htrans_type            htrans,
   output logic                  hwrite,
   output hburst_type            hburst,
   output logic                  beat_done,
   output logic                  xfer_done
);

   state_type             state;
   state_type             state_nxt;
   logic [3:0]            count;
   logic [3:0]            limit;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic                  adv;
   logic                  last_beat;
   logic [10:0]           burst_end;

   assign adv       = hgrant & ~hwait;
   assign last_beat = ((state == S_REQ) && (limit == 4'd0)) ||
                      ((state == S_XFER) && (count == limit));

   ahb_addr_next #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .BYTES_PER_BEAT (BYTES_PER_BEAT)
   ) u_addr_next (
      .haddr     (haddr),
      .hburst    (hburst),
      .next_addr (addr_next)
   );

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) state <= S_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:        if (cmd_valid) state_nxt = S_REQ;
         S_REQ, S_XFER: if (adv) state_nxt = last_beat ? S_IDLE : S_XFER;
         default:       state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         haddr  <= '0;
         hwrite <= 1'b0;
         hburst <= SINGLE;
         limit  <= 4'd0;
         count  <= 4'd0;
      end else if (state == S_IDLE) begin
         if (cmd_valid) begin
            haddr  <= cmd_addr;
            hwrite <= cmd_write;
            hburst <= cmd_burst;
            limit  <= beat_limit(cmd_burst, cmd_len);
            count  <= 4'd0;
         end
      end else if (adv && !last_beat) begin
         count <= count + 4'd1;
         haddr <= addr_next;
      end
   end

   // hreq and htrans decode straight from the state register, so both drop with the IDLE return.
   always_comb begin
      cmd_ready = (state == S_IDLE);
      hreq      = (state != S_IDLE);
      beat_done = adv && (state != S_IDLE);
      xfer_done = adv && last_beat;
      case (state)
         S_REQ:   htrans = NONSEQ;
         S_XFER:  htrans = SEQ;
         default: htrans = IDLE;
      endcase
   end

   assign burst_end = 11'(cmd_addr[9:0]) +
                      11'((32'(beat_limit(cmd_burst, cmd_len)) + 1) * BYTES_PER_BEAT);

   a_no_grant_in_idle: assert property (@(posedge hclk) disable iff (!hreset_n)
      (state == S_IDLE) |-> !hgrant);

   a_incr_within_1kb: assert property (@(posedge hclk) disable iff (!hreset_n)
      ((state == S_IDLE) && cmd_valid && (cmd_burst inside {INCR, INCR4, INCR8, INCR16}))
      |-> (burst_end <= 11'd1024));

endmodule

// File: doc/ahb_master_req_ctrl.md
Name: ahb_master_req_ctrl

Overview:
- Master-side counterpart of the per-slave arbiter. It accepts one burst command from local master logic and raises hreq toward the slave arbiter.
- It drives the AHB address/control phase beat by beat. Each beat advances only on hgrant (arbiter grant already qualified by ~hwait).
- hreq is dropped after the final beat is accepted, so the arbiter's burst monitor and this block see the same burst boundary.
- One instance per master per target path. Data phase is out of scope; the master datapath handles it.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr/haddr
BYTES_PER_BEAT, 4, transfer size in bytes (power of 2); address step per beat

Ports:
hclk  in  1  clock
hreset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request from local master
cmd_ready  out  1  block can accept a command (IDLE only)
cmd_addr  in  ADDR_WIDTH  start address, aligned to BYTES_PER_BEAT
cmd_write  in  1  1=write, 0=read
cmd_burst  in  hburst_type  SINGLE/INCR/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16
cmd_len  in  4  beats-1; used only for INCR (0..15 -> 1..16 beats)
hreq  out  1  bus request to slave arbiter
hgrant  in  1  beat accepted this cycle (grant & ~hwait from arbiter)
hwait  in  1  slave wait; stalls the current beat
haddr  out  ADDR_WIDTH  current beat address
htrans  out  htrans_type  IDLE/NONSEQ/SEQ
hwrite  out  1  registered cmd_write
hburst  out  hburst_type  registered cmd_burst, held for the whole burst
beat_done  out  1  one-cycle pulse per accepted beat (= hgrant while active)
xfer_done  out  1  one-cycle pulse on the accepted last beat

Behaviour:
- Reset values: state=IDLE, hreq=0, haddr=0, htrans=IDLE, hwrite=0, hburst=SINGLE, beat count=0. cmd_ready=1, beat_done=0, xfer_done=0.
- Beat limit, held in a register:
  - SINGLE=0; INCR=cmd_len; WRAP4/INCR4=3; WRAP8/INCR8=7; WRAP16/INCR16=15.
  - The arbiter's count_limit uses the same encoding.
- FSM states: IDLE, REQ, XFER.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture addr/write/burst/limit, set hreq<=1, count<=0, go to REQ.
- REQ:
  - htrans=NONSEQ, haddr=start address, hreq=1.
  - On hgrant: if limit==0, go to IDLE, clear hreq, pulse xfer_done. Otherwise count<=1, haddr<=next, go to XFER.
- XFER:
  - htrans=SEQ, hreq=1.
  - On hgrant with count==limit: go to IDLE, hreq<=0, htrans<=IDLE, pulse xfer_done.
  - Otherwise count<=count+1, haddr<=next.
- Latency:
  - hreq rises one cycle after cmd handshake.
  - hreq falls the cycle after the last hgrant.
  - Minimum one IDLE cycle between bursts, so cmd_ready reasserts the cycle after xfer_done.
- Stall rule: hwait=1 or hgrant=0 holds haddr, htrans, count and state unchanged. No beat is ever skipped or duplicated.
- Next address:
  - INCR*/INCR/SINGLE: haddr+BYTES_PER_BEAT.
  - WRAPn: mask=n*BYTES_PER_BEAT-1; next=(haddr & ~mask) | ((haddr+BYTES_PER_BEAT) & mask).
- Boundary rules:
  - INCR bursts crossing a 1 KB boundary are illegal input. An assertion in the block flags them; RTL behaviour is then unspecified.
  - cmd_valid while not IDLE is ignored (cmd_ready=0).
  - hgrant in IDLE is ignored; an assertion flags it.
  - Reset mid-burst returns all outputs to reset values immediately (async) and discards the command.
- Count width is 4 bits; no wrap-around, because it never exceeds limit ≤15.

Decomposition:
- AHB_package gains:
  - htrans_type enum (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11).
  - beat-limit function from hburst_type+len, shared with the arbiter monitor.
- One combinational sub-module, ahb_addr_next: inputs haddr, hburst; output next address (incr/wrap logic). Parameterised by ADDR_WIDTH and BYTES_PER_BEAT.

Test Plan:
- INCR4 at 0x100, hgrant every cycle from REQ:
  - haddr 0x100,0x104,0x108,0x10C; htrans NONSEQ,SEQ,SEQ,SEQ.
  - xfer_done on beat 4; hreq=0 next cycle.
- WRAP4 at 0x38: haddr 0x38,0x3C,0x30,0x34; 4 beat_done pulses; hburst=WRAP4 held throughout.
- INCR8 at 0x200 with hwait=1 (hgrant=0) for 2 cycles on beat 3: haddr held at 0x208 for 3 cycles, count unchanged, total beats=8, last haddr=0x21C.
- SINGLE at 0x40, then cmd_valid held high:
  - one NONSEQ beat, xfer_done with the grant.
  - cmd_ready=0 during REQ, =1 the cycle after; second command captured then.
- INCR cmd_len=15 at 0x000 with random hgrant gaps: exactly 16 beats, final haddr=0x03C, hreq falls after the 16th hgrant.
- Reset asserted during beat 2 of WRAP8: all outputs at reset values in the same cycle; after release, cmd_ready=1 and hreq=0.
